// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, memory geometry, ACK levels.
package i2c_pkg;

  localparam int unsigned I2C_MEM_DEPTH = 128;
  localparam int unsigned I2C_PTR_W     = 7;

  // SDA level during the acknowledge bit
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus a third stage for edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] synchronize; [2] is the previous synchronized value
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  // Shift pins through the synchronizer chain; reset to the idle bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sh <= '1;
      sda_sh <= '1;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_i};
      sda_sh <= {sda_sh[1:0], sda_i};
    end
  end

  assign sda_sync  = sda_sh[1];
  assign scl_rise  =  scl_sh[1] & ~scl_sh[2];
  assign scl_fall  = ~scl_sh[1] &  scl_sh[2];
  assign start_det =  scl_sh[1] &  scl_sh[2] & ~sda_sh[1] &  sda_sh[2];
  assign stop_det  =  scl_sh[1] &  scl_sh[2] &  sda_sh[1] & ~sda_sh[2];

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a 128-byte memory, word pointer with auto-increment, open-drain SDA.
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 wr_stb,
  output logic [I2C_PTR_W-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic [I2C_PTR_W-1:0] ptr
);

  logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_sync  (sda_sync),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  logic [7:0] mem [I2C_MEM_DEPTH];
  logic [7:0] rd_byte;
  logic [7:0] byte_in;

  i2c_state_t state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       rw;
  logic       phase;   // ACK states: 0 = waiting to drive, 1 = driving / ACK seen

  assign rd_byte = mem[ptr];
  assign byte_in = {shreg[6:0], sda_sync};

  // Memory write one cycle behind the committed-byte strobe; not reset
  always_ff @(posedge clk) begin
    if (wr_stb) mem[wr_addr] <= wr_data;
  end

  // Protocol FSM: START/STOP override everything, bits sampled on scl_rise, SDA driven after scl_fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bitcnt  <= 3'd7;
      shreg   <= '0;
      rw      <= 1'b0;
      phase   <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ptr     <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state  <= ST_ADDR;
        bitcnt <= 3'd7;
        sda_oe <= 1'b0;
        phase  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        phase  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ADDR: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                busy  <= 1'b1;
                rw    <= byte_in[0];
                state <= ST_ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              ptr   <= byte_in[6:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              wr_stb  <= 1'b1;
              wr_addr <= ptr;
              wr_data <= byte_in;
              ptr     <= ptr + 7'd1;
              state   <= ST_WDATA_ACK;
            end
          end
          // First fall drives ACK, second fall releases and moves on; a read starts its MSB here
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              phase  <= 1'b0;
              bitcnt <= 3'd7;
              if (state == ST_ADDR_ACK) begin
                if (rw) begin
                  state  <= ST_RDATA;
                  shreg  <= rd_byte;
                  sda_oe <= ~rd_byte[7];
                end else begin
                  state <= ST_PTR;
                end
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          // bitcnt names the bit currently on the bus; the fall after bit 0 ends the byte
          ST_RDATA: if (scl_fall) begin
            if (bitcnt == 3'd0) begin
              sda_oe <= 1'b0;
              ptr    <= ptr + 7'd1;
              phase  <= 1'b0;
              state  <= ST_RDATA_ACK;
            end else begin
              sda_oe <= ~shreg[bitcnt - 3'd1];
              bitcnt <= bitcnt - 3'd1;
            end
          end
          // ACK seen on the rise, next byte's MSB driven on the following fall
          ST_RDATA_ACK: begin
            if (!phase) begin
              if (scl_rise) begin
                if (sda_sync == I2C_ACK) begin
                  phase <= 1'b1;
                end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              end
            end else if (scl_fall) begin
              phase  <= 1'b0;
              bitcnt <= 3'd7;
              shreg  <= rd_byte;
              sda_oe <= ~rd_byte[7];
              state  <= ST_RDATA;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-level I2C initiator, transaction-level memory/pointer model.
module tb_i2c_target_mem;

  localparam int Q = 40;   // quarter SCL period; SCL = clk/16

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, busy, wr_stb;
  logic [6:0] wr_addr, ptr;
  logic [7:0] wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_mem #(.DEV_ADDR(7'h50)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ptr     (ptr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: memory contents, pointer, and writes that must appear on wr_stb
  logic [7:0]  mmem [128];
  logic [6:0]  mptr = 7'h00;
  logic [14:0] expq [$];
  int          wr_cnt = 0;
  int          oe_rises = 0;
  logic        oe_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every committed write must match the model's next expected write,
  // and SDA may only start being pulled low while SCL is low
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_stb_unexpected: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
        end else begin
          chk("wr_stb_addr_data", {17'd0, wr_addr, wr_data}, {17'd0, expq.pop_front()});
        end
      end
      if (sda_oe && !oe_prev) begin
        oe_rises++;
        chk("oe_rise_scl_low", {31'd0, scl_m}, 32'd0);
      end
    end
    oe_prev = sda_oe;
  end

  // ---- bit-level initiator ----
  task automatic bit_out(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) bit_in(d[i]);
    bit_out(nack);
  endtask

  // ---- transaction helpers updating the model ----
  task automatic addr_ptr(input logic [6:0] p, input string tag);
    logic a;
    i2c_start();
    write_byte(8'hA0, a); chk({tag, "_addr_ack"}, {31'd0, a}, 32'd0);
    write_byte({1'b0, p}, a); chk({tag, "_ptr_ack"}, {31'd0, a}, 32'd0);
    mptr = p;
  endtask

  task automatic wdata(input logic [7:0] d, input string tag);
    logic a;
    expq.push_back({mptr, d});
    write_byte(d, a); chk({tag, "_data_ack"}, {31'd0, a}, 32'd0);
    mmem[mptr] = d;
    mptr = mptr + 7'd1;
  endtask

  task automatic rdata(input logic nack, output logic [7:0] d, input string tag);
    read_byte(d, nack);
    chk({tag, "_rd_model"}, {24'd0, d}, {24'd0, mmem[mptr]});
    mptr = mptr + 7'd1;
  endtask

  task automatic read_start(input string tag);
    logic a;
    i2c_start();
    write_byte(8'hA1, a); chk({tag, "_raddr_ack"}, {31'd0, a}, 32'd0);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       a;
    int         snap_wr, snap_oe;

    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_ptr", {25'd0, ptr}, 32'd0);

    // Write 0xA5, 0x3C at 0x10
    addr_ptr(7'h10, "wr");
    wdata(8'hA5, "wr0");
    wdata(8'h3C, "wr1");
    chk("wr_busy_before_stop", {31'd0, busy}, 32'd1);
    i2c_stop();
    settle();
    chk("wr_ptr_literal", {25'd0, ptr}, 32'h12);
    chk("wr_ptr_model", {25'd0, ptr}, {25'd0, mptr});
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    chk("wr_queue_drained", expq.size(), 32'd0);
    chk("wr_count", wr_cnt, 32'd2);

    // Random read via repeated START
    addr_ptr(7'h10, "rd");
    read_start("rd");
    rdata(1'b0, d, "rd0"); chk("rd0_literal", {24'd0, d}, 32'hA5);
    rdata(1'b1, d, "rd1"); chk("rd1_literal", {24'd0, d}, 32'h3C);
    settle();
    chk("rd_busy_after_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    settle();
    chk("rd_ptr_literal", {25'd0, ptr}, 32'h12);

    // Address mismatch
    snap_wr = wr_cnt; snap_oe = oe_rises;
    i2c_start();
    write_byte(8'hA2, a);
    chk("mm_nack", {31'd0, a}, 32'd1);
    chk("mm_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h55, a);
    chk("mm_data_nack", {31'd0, a}, 32'd1);
    i2c_stop();
    settle();
    chk("mm_no_oe", oe_rises, snap_oe);
    chk("mm_no_write", wr_cnt, snap_wr);
    chk("mm_ptr", {25'd0, ptr}, {25'd0, mptr});

    // Pointer wrap on write and read
    addr_ptr(7'h7F, "wrap");
    wdata(8'h11, "wrap0");
    wdata(8'h22, "wrap1");
    i2c_stop();
    settle();
    chk("wrap_wr_ptr", {25'd0, ptr}, 32'h01);
    chk("wrap_queue_drained", expq.size(), 32'd0);
    addr_ptr(7'h7F, "wrapr");
    read_start("wrapr");
    rdata(1'b0, d, "wrapr0"); chk("wrapr0_literal", {24'd0, d}, 32'h11);
    rdata(1'b1, d, "wrapr1"); chk("wrapr1_literal", {24'd0, d}, 32'h22);
    i2c_stop();
    settle();
    chk("wrapr_ptr", {25'd0, ptr}, 32'h01);

    // STOP after 4 data bits: no commit, next transfer still works
    addr_ptr(7'h20, "mid");
    snap_wr = wr_cnt;
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    i2c_stop();
    settle();
    chk("mid_no_write", wr_cnt, snap_wr);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ptr", {25'd0, ptr}, 32'h20);
    addr_ptr(7'h30, "mid2");
    wdata(8'h77, "mid2");
    i2c_stop();
    settle();
    chk("mid2_ptr", {25'd0, ptr}, 32'h31);
    chk("mid2_queue_drained", expq.size(), 32'd0);

    // Reset while driving a 0 data bit
    addr_ptr(7'h40, "pre");
    wdata(8'h00, "pre");
    i2c_stop();
    settle();
    addr_ptr(7'h40, "rrst");
    read_start("rrst");
    @(negedge clk);
    chk("rrst_driving_zero", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rrst_busy", {31'd0, busy}, 32'd0);
    chk("rrst_ptr", {25'd0, ptr}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = 7'h00;
    settle();
    chk("post_rst_ptr", {25'd0, ptr}, {25'd0, mptr});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
